alu_operand_aligner: RTL and testbench

//   Input staging block directly upstream of the ALU.

---
 rtl/alu_operand_aligner.sv | 179 +++++++++++++++++
 tb/tb_alu_operand_aligner.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_aligner.sv
// Input staging for the ALU: three skewed valid-qualified streams (operand A, operand B,
// command) are each buffered in order and issued together as one registered triple.

module OperandQueue #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         nonempty_o,
    output logic         drop_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          accept;

    // A full queue still accepts a push when the head leaves on the same edge.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        accept   = push_i && (!full || pop_i);
        drop_o   = push_i && full && !pop_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({accept, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign nonempty_o = (count_q != '0);

endmodule

module alu_operand_aligner #(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_a_vld,
    input  logic [DATA_W-1:0] op_a_data,
    input  logic              op_b_vld,
    input  logic [DATA_W-1:0] op_b_data,
    input  logic              cmd_vld,
    input  logic [CMD_W-1:0]  cmd_code,
    input  logic              alu_stall,
    input  logic              clr_err,
    output logic              alu_op_a_vld,
    output logic [DATA_W-1:0] alu_op_a,
    output logic              alu_op_b_vld,
    output logic [DATA_W-1:0] alu_op_b,
    output logic              alu_cmd_vld,
    output logic [CMD_W-1:0]  alu_cmd,
    output logic [2:0]        ovf_err
);
    logic [DATA_W-1:0] head_a, head_b;
    logic [CMD_W-1:0]  head_c;
    logic              ne_a, ne_b, ne_c;
    logic              drop_a, drop_b, drop_c;
    logic              issue;

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [2:0]        ovf_q, ovf_d;

    OperandQueue #(.W(DATA_W), .DEPTH(DEPTH)) u_qa (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (op_a_vld),
        .data_i    (op_a_data),
        .pop_i     (issue),
        .head_o    (head_a),
        .nonempty_o(ne_a),
        .drop_o    (drop_a)
    );

    OperandQueue #(.W(DATA_W), .DEPTH(DEPTH)) u_qb (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (op_b_vld),
        .data_i    (op_b_data),
        .pop_i     (issue),
        .head_o    (head_b),
        .nonempty_o(ne_b),
        .drop_o    (drop_b)
    );

    OperandQueue #(.W(CMD_W), .DEPTH(DEPTH)) u_qc (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (cmd_vld),
        .data_i    (cmd_code),
        .pop_i     (issue),
        .head_o    (head_c),
        .nonempty_o(ne_c),
        .drop_o    (drop_c)
    );

    // A new overflow on the same edge as clr_err must survive the clear.
    always_comb begin
        issue  = ne_a && ne_b && ne_c && !alu_stall;
        vld_d  = issue;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        cmd_d  = cmd_q;
        if (issue) begin
            op_a_d = head_a;
            op_b_d = head_b;
            cmd_d  = head_c;
        end
        ovf_d = {drop_c, drop_b, drop_a} | (clr_err ? 3'b000 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            op_a_q <= '0;
            op_b_q <= '0;
            cmd_q  <= '0;
            ovf_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            cmd_q  <= cmd_d;
            ovf_q  <= ovf_d;
        end
    end

    assign alu_op_a_vld = vld_q;
    assign alu_op_b_vld = vld_q;
    assign alu_cmd_vld  = vld_q;
    assign alu_op_a     = op_a_q;
    assign alu_op_b     = op_b_q;
    assign alu_cmd      = cmd_q;
    assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_alu_operand_aligner.sv
// Scoreboard bench for alu_operand_aligner: tasks push expected triples as they drive
// stimulus, a negedge monitor pops and compares every issued triple.

module tb_alu_operand_aligner;
    localparam int DATA_W = 8;
    localparam int CMD_W  = 3;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              op_a_vld = 1'b0;
    logic [DATA_W-1:0] op_a_data = '0;
    logic              op_b_vld = 1'b0;
    logic [DATA_W-1:0] op_b_data = '0;
    logic              cmd_vld = 1'b0;
    logic [CMD_W-1:0]  cmd_code = '0;
    logic              alu_stall = 1'b0;
    logic              clr_err = 1'b0;
    logic              alu_op_a_vld, alu_op_b_vld, alu_cmd_vld;
    logic [DATA_W-1:0] alu_op_a, alu_op_b;
    logic [CMD_W-1:0]  alu_cmd;
    logic [2:0]        ovf_err;

    int total = 0;
    int bad   = 0;
    logic [DATA_W*2+CMD_W-1:0] sb[$];

    always #5 clk = ~clk;

    alu_operand_aligner #(.DATA_W(DATA_W), .CMD_W(CMD_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_a_vld    (op_a_vld),
        .op_a_data   (op_a_data),
        .op_b_vld    (op_b_vld),
        .op_b_data   (op_b_data),
        .cmd_vld     (cmd_vld),
        .cmd_code    (cmd_code),
        .alu_stall   (alu_stall),
        .clr_err     (clr_err),
        .alu_op_a_vld(alu_op_a_vld),
        .alu_op_a    (alu_op_a),
        .alu_op_b_vld(alu_op_b_vld),
        .alu_op_b    (alu_op_b),
        .alu_cmd_vld (alu_cmd_vld),
        .alu_cmd     (alu_cmd),
        .ovf_err     (ovf_err)
    );

    // Every issued triple must match the oldest expected one, with all three valids high.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (alu_op_a_vld | alu_op_b_vld | alu_cmd_vld) !== 1'b0) begin
            logic [DATA_W*2+CMD_W-1:0] exp;
            total++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL unexpected_issue: got a=%h b=%h cmd=%0d, required no issue",
                         alu_op_a, alu_op_b, alu_cmd);
                bad++;
            end else begin
                exp = sb.pop_front();
                if ({alu_op_a_vld, alu_op_b_vld, alu_cmd_vld, alu_op_a, alu_op_b, alu_cmd}
                    !== {3'b111, exp}) begin
                    $display("[TB] FAIL issue_triple: got vld=%b%b%b a=%h b=%h cmd=%0d, required vld=111 a=%h b=%h cmd=%0d",
                             alu_op_a_vld, alu_op_b_vld, alu_cmd_vld, alu_op_a, alu_op_b, alu_cmd,
                             exp[18:11], exp[10:3], exp[2:0]);
                    bad++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        op_a_vld = 1'b0;
        op_b_vld = 1'b0;
        cmd_vld  = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
        op_a_vld = 1'b1; op_a_data = a;
        op_b_vld = 1'b1; op_b_data = b;
        cmd_vld  = 1'b1; cmd_code  = c;
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({alu_op_a_vld, alu_op_b_vld, alu_cmd_vld, alu_op_a, alu_op_b, alu_cmd, ovf_err} !== '0) begin
            $display("[TB] FAIL reset_outputs: got %h, required 0",
                     {alu_op_a_vld, alu_op_b_vld, alu_cmd_vld, alu_op_a, alu_op_b, alu_cmd, ovf_err});
            bad++;
        end
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_aligned;
        push3(8'h05, 8'h03, 3'd1);
        sb.push_back({8'h05, 8'h03, 3'd1});
        tick();
        idle();
        total++;
        if ({alu_op_a_vld, alu_op_b_vld, alu_cmd_vld} !== 3'b000) begin
            $display("[TB] FAIL aligned_k1: got vld=%b, required 000", {alu_op_a_vld, alu_op_b_vld, alu_cmd_vld});
            bad++;
        end
        tick();
        total++;
        if ({alu_op_a_vld, alu_op_b_vld, alu_cmd_vld, alu_op_a, alu_op_b, alu_cmd} !== {3'b111, 8'h05, 8'h03, 3'd1}) begin
            $display("[TB] FAIL aligned_k2: got vld=%b a=%h b=%h cmd=%0d, required 111 05 03 1",
                     {alu_op_a_vld, alu_op_b_vld, alu_cmd_vld}, alu_op_a, alu_op_b, alu_cmd);
            bad++;
        end
        tick();
        total++;
        if ({alu_op_a_vld, alu_op_b_vld, alu_cmd_vld, alu_op_a} !== {3'b000, 8'h05}) begin
            $display("[TB] FAIL aligned_k3: got vld=%b a=%h, required 000 05 (held)",
                     {alu_op_a_vld, alu_op_b_vld, alu_cmd_vld}, alu_op_a);
            bad++;
        end
    endtask

    task automatic test_reset_mid_burst;
        int issues = 0;
        alu_stall = 1'b1;
        push3(8'h11, 8'h22, 3'd3);
        tick();
        push3(8'h12, 8'h23, 3'd4);
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({alu_op_a_vld, alu_op_b_vld, alu_cmd_vld, alu_op_a, alu_op_b, alu_cmd, ovf_err} !== '0) begin
            $display("[TB] FAIL midreset_outputs: got %h, required 0",
                     {alu_op_a_vld, alu_op_b_vld, alu_cmd_vld, alu_op_a, alu_op_b, alu_cmd, ovf_err});
            bad++;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        alu_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (alu_op_a_vld !== 1'b0) issues++;
        end
        total++;
        if (issues != 0) begin
            $display("[TB] FAIL midreset_flush: got %0d issues after release, required 0", issues);
            bad++;
        end
    endtask

    task automatic test_skew;
        int pulses = 0;
        int at = -1;
        for (int c = 0; c < 10; c++) begin
            op_a_vld = (c == 0); op_a_data = 8'h5A;
            op_b_vld = (c == 3); op_b_data = 8'hA5;
            cmd_vld  = (c == 5); cmd_code  = 3'd6;
            if (c == 5) sb.push_back({8'h5A, 8'hA5, 3'd6});
            tick();
            if (alu_op_a_vld === 1'b1) begin
                pulses++;
                at = c + 1;
            end
        end
        idle();
        total++;
        if (pulses != 1 || at != 7) begin
            $display("[TB] FAIL skew_timing: got %0d pulses last at cycle k+%0d, required 1 at k+7", pulses, at);
            bad++;
        end
    endtask

    task automatic test_stall_order;
        int run = 0;
        alu_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push3(8'(i + 1), 8'(i + 5), 3'(i));
            sb.push_back({8'(i + 1), 8'(i + 5), 3'(i)});
            tick();
        end
        idle();
        tick();
        total++;
        if (alu_op_a_vld !== 1'b0) begin
            $display("[TB] FAIL stall_hold: got vld=%b, required 0", alu_op_a_vld);
            bad++;
        end
        alu_stall = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (alu_op_a_vld === 1'b1) run++;
            tick();
        end
        total++;
        if (run != 4) begin
            $display("[TB] FAIL stall_burst: got %0d consecutive issues, required 4", run);
            bad++;
        end
    endtask

    task automatic test_overflow;
        alu_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op_a_vld = 1'b1; op_a_data = 8'(10 + i);
            tick();
            if (i == 3) begin
                total++;
                if (ovf_err !== 3'b000) begin
                    $display("[TB] FAIL ovf_at_full: got %b, required 000", ovf_err);
                    bad++;
                end
            end
        end
        idle();
        total++;
        if (ovf_err !== 3'b001) begin
            $display("[TB] FAIL ovf_set: got %b, required 001", ovf_err);
            bad++;
        end
        tick();
        total++;
        if (ovf_err !== 3'b001) begin
            $display("[TB] FAIL ovf_sticky: got %b, required 001", ovf_err);
            bad++;
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        total++;
        if (ovf_err !== 3'b000) begin
            $display("[TB] FAIL ovf_clear: got %b, required 000", ovf_err);
            bad++;
        end
        for (int i = 0; i < 4; i++) begin
            op_b_vld = 1'b1; op_b_data = 8'(20 + i);
            cmd_vld  = 1'b1; cmd_code  = 3'(i);
            sb.push_back({8'(10 + i), 8'(20 + i), 3'(i)});
            tick();
        end
        idle();
        drain();
        total++;
        if (sb.size() != 0) begin
            $display("[TB] FAIL ovf_drain: got %0d pending triples, required 0", sb.size());
            bad++;
            sb.delete();
        end
    endtask

    task automatic test_set_wins;
        for (int i = 0; i < 5; i++) begin
            op_a_vld = 1'b1; op_a_data = 8'(8'h60 + i);
            clr_err  = (i == 4);
            tick();
        end
        idle();
        total++;
        if (ovf_err !== 3'b001) begin
            $display("[TB] FAIL set_wins: got %b, required 001", ovf_err);
            bad++;
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_b_vld = 1'b1; op_b_data = 8'(8'h70 + i);
            cmd_vld  = 1'b1; cmd_code  = 3'(7 - i);
            sb.push_back({8'(8'h60 + i), 8'(8'h70 + i), 3'(7 - i)});
            tick();
        end
        idle();
        drain();
        total++;
        if (sb.size() != 0 || ovf_err !== 3'b000) begin
            $display("[TB] FAIL set_wins_drain: got pending=%0d ovf=%b, required 0 000", sb.size(), ovf_err);
            bad++;
            sb.delete();
        end
    endtask

    task automatic test_full_push_pop;
        alu_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push3(8'(8'h30 + i), 8'(8'h40 + i), 3'(i));
            sb.push_back({8'(8'h30 + i), 8'(8'h40 + i), 3'(i)});
            tick();
        end
        idle();
        tick();
        alu_stall = 1'b0;
        op_a_vld = 1'b1; op_a_data = 8'h34;
        tick();
        idle();
        total++;
        if (ovf_err !== 3'b000 || alu_op_a_vld !== 1'b1) begin
            $display("[TB] FAIL full_pushpop: got ovf=%b vld=%b, required 000 1", ovf_err, alu_op_a_vld);
            bad++;
        end
        drain();
        op_b_vld = 1'b1; op_b_data = 8'h44;
        cmd_vld  = 1'b1; cmd_code  = 3'd4;
        sb.push_back({8'h34, 8'h44, 3'd4});
        tick();
        idle();
        drain();
        total++;
        if (sb.size() != 0 || ovf_err !== 3'b000) begin
            $display("[TB] FAIL full_pushpop_drain: got pending=%0d ovf=%b, required 0 000", sb.size(), ovf_err);
            bad++;
            sb.delete();
        end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        int first = -1;
        int last = -1;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                logic [7:0] a, b;
                logic [2:0] k;
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                k = 3'($urandom_range(0, 7));
                push3(a, b, k);
                sb.push_back({a, b, k});
            end else begin
                idle();
            end
            tick();
            if (alu_op_a_vld === 1'b1) begin
                pulses++;
                if (first < 0) first = c + 1;
                last = c + 1;
            end
        end
        total++;
        if (pulses != 8 || first != 2 || last != 9) begin
            $display("[TB] FAIL back_to_back: got %0d issues in cycles %0d..%0d, required 8 in 2..9", pulses, first, last);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_reset_mid_burst();
        test_skew();
        test_stall_order();
        test_overflow();
        test_set_wins();
        test_full_push_pop();
        test_back_to_back();
        tick();
        total++;
        if (sb.size() != 0) begin
            $display("[TB] FAIL final_scoreboard: got %0d unissued triples, required 0", sb.size());
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
